// File: rtl/tile_fetch_addr_if.sv
// Handshake bundle between the tile controller, tile_fetch_addr and the line-buffer fetch stage.
// The slave modport is the address generator's view; master is the surrounding logic.
interface tile_fetch_addr_if #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [DIM_W-1:0]          cfg_img_h;
    logic [DIM_W-1:0]          cfg_img_w;
    logic [ADDR_W-1:0]         cfg_base;

    logic                      desc_valid;
    logic                      desc_ready;
    logic signed [DIM_W:0]     desc_in_row;
    logic signed [DIM_W:0]     desc_in_col;
    logic [DIM_W-1:0]          desc_in_h;
    logic [DIM_W-1:0]          desc_in_w;

    logic                      pix_valid;
    logic                      pix_ready;
    logic [ADDR_W-1:0]         pix_addr;
    logic                      pix_pad;
    logic [2*DIM_W-1:0]        pix_buf_idx;
    logic                      pix_first;
    logic                      pix_last;
    logic                      done;

    modport master (
        output cfg_valid, cfg_img_h, cfg_img_w, cfg_base,
        output desc_valid, desc_in_row, desc_in_col, desc_in_h, desc_in_w,
        output pix_ready,
        input  cfg_ready, desc_ready,
        input  pix_valid, pix_addr, pix_pad, pix_buf_idx, pix_first, pix_last, done
    );

    modport slave (
        input  cfg_valid, cfg_img_h, cfg_img_w, cfg_base,
        input  desc_valid, desc_in_row, desc_in_col, desc_in_h, desc_in_w,
        input  pix_ready,
        output cfg_ready, desc_ready,
        output pix_valid, pix_addr, pix_pad, pix_buf_idx, pix_first, pix_last, done
    );
endinterface

// File: rtl/tile_fetch_addr.sv
// Walks one input window per descriptor in raster order, emitting a beat per cycle with the
// feature-map word address, or a padding flag when the pixel lies outside the image.
module tile_fetch_addr #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              rst,
    tile_fetch_addr_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int         IDX_W   = 2 * DIM_W;

    logic [1:0]            state_q, state_d;
    logic                  cfg_loaded_q, cfg_loaded_d;
    logic [DIM_W-1:0]      img_h_q, img_h_d;
    logic [DIM_W-1:0]      img_w_q, img_w_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic signed [DIM_W:0] in_row_q, in_row_d;
    logic signed [DIM_W:0] in_col_q, in_col_d;
    logic [DIM_W-1:0]      h_q, h_d;
    logic [DIM_W-1:0]      w_q, w_d;
    logic [DIM_W-1:0]      r_q, r_d;
    logic [DIM_W-1:0]      c_q, c_d;

    logic signed [DIM_W+1:0] ir;
    logic signed [DIM_W+1:0] ic;
    logic                    pad;
    logic                    col_end;
    logic                    row_end;
    logic                    cfg_acc;
    logic                    desc_acc;
    logic                    beat_acc;
    logic                    desc_zero;

    // Sign bit catches top/left padding; the extra headroom bit keeps in_row + r from wrapping.
    function automatic logic out_of_image(input logic signed [DIM_W+1:0] row,
                                          input logic signed [DIM_W+1:0] col,
                                          input logic [DIM_W-1:0]        img_h,
                                          input logic [DIM_W-1:0]        img_w);
        return row[DIM_W+1] || (row >= $signed({2'b00, img_h})) ||
               col[DIM_W+1] || (col >= $signed({2'b00, img_w}));
    endfunction

    // Only called for in-image pixels, so row/col are non-negative; the sum wraps at ADDR_W.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ADDR_W-1:0]       base,
                                                     input logic signed [DIM_W+1:0] row,
                                                     input logic signed [DIM_W+1:0] col,
                                                     input logic [DIM_W-1:0]        img_w);
        logic [ADDR_W-1:0] row_a;
        logic [ADDR_W-1:0] col_a;
        logic [ADDR_W-1:0] w_a;
        row_a = ADDR_W'($unsigned(row));
        col_a = ADDR_W'($unsigned(col));
        w_a   = ADDR_W'(img_w);
        return base + row_a * w_a + col_a;
    endfunction

    assign ir = $signed({in_row_q[DIM_W], in_row_q}) + $signed({2'b00, r_q});
    assign ic = $signed({in_col_q[DIM_W], in_col_q}) + $signed({2'b00, c_q});

    assign pad       = out_of_image(ir, ic, img_h_q, img_w_q);
    assign col_end   = (c_q == w_q - DIM_W'(1));
    assign row_end   = (r_q == h_q - DIM_W'(1));
    assign cfg_acc   = bus.cfg_valid && (state_q == ST_IDLE);
    assign desc_acc  = bus.desc_valid && (state_q == ST_IDLE) && cfg_loaded_q;
    assign beat_acc  = bus.pix_ready && (state_q == ST_RUN);
    assign desc_zero = (bus.desc_in_h == '0) || (bus.desc_in_w == '0);

    always_comb begin
        state_d      = state_q;
        cfg_loaded_d = cfg_loaded_q;
        img_h_d      = img_h_q;
        img_w_d      = img_w_q;
        base_d       = base_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        h_d          = h_q;
        w_d          = w_q;
        r_d          = r_q;
        c_d          = c_q;

        if (cfg_acc) begin
            img_h_d      = bus.cfg_img_h;
            img_w_d      = bus.cfg_img_w;
            base_d       = bus.cfg_base;
            cfg_loaded_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (desc_acc) begin
                    in_row_d = bus.desc_in_row;
                    in_col_d = bus.desc_in_col;
                    h_d      = bus.desc_in_h;
                    w_d      = bus.desc_in_w;
                    r_d      = '0;
                    c_d      = '0;
                    state_d  = desc_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_acc) begin
                    if (col_end) begin
                        c_d = '0;
                        r_d = r_q + DIM_W'(1);
                    end else begin
                        c_d = c_q + DIM_W'(1);
                    end
                    if (col_end && row_end) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cfg_loaded_q <= 1'b0;
            img_h_q      <= '0;
            img_w_q      <= '0;
            base_q       <= '0;
            in_row_q     <= '0;
            in_col_q     <= '0;
            h_q          <= '0;
            w_q          <= '0;
            r_q          <= '0;
            c_q          <= '0;
        end else begin
            state_q      <= state_d;
            cfg_loaded_q <= cfg_loaded_d;
            img_h_q      <= img_h_d;
            img_w_q      <= img_w_d;
            base_q       <= base_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            h_q          <= h_d;
            w_q          <= w_d;
            r_q          <= r_d;
            c_q          <= c_d;
        end
    end

    // Beat outputs derive only from registered state, so they hold while the consumer stalls.
    assign bus.cfg_ready   = (state_q == ST_IDLE);
    assign bus.desc_ready  = (state_q == ST_IDLE) && cfg_loaded_q;
    assign bus.pix_valid   = (state_q == ST_RUN);
    assign bus.pix_pad     = pad;
    assign bus.pix_addr    = pad ? '0 : pixel_addr(base_q, ir, ic, img_w_q);
    assign bus.pix_buf_idx = IDX_W'(r_q) * IDX_W'(w_q) + IDX_W'(c_q);
    assign bus.pix_first   = (r_q == '0) && (c_q == '0);
    assign bus.pix_last    = col_end && row_end;
    assign bus.done        = (state_q == ST_DONE);
endmodule

// File: doc/tile_fetch_addr.md
# tile_fetch_addr

Input-window address generator sitting directly downstream of the tile controller. It accepts one tile descriptor at a time: a signed input-window origin plus input-window height and width. It then walks the window in raster order, emitting one pixel beat per cycle, each with its feature-map read address or a padding flag. The line-buffer/fetch stage consumes these beats and fills the tile input buffer.

## Interface
- DIM_W, 16, width of all dimension fields; origins are DIM_W+1 signed
- ADDR_W, 32, width of the feature-map word address
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_valid  in  1  config handshake valid
- cfg_ready  out  1  high when idle
- cfg_img_h, cfg_img_w  in  DIM_W  feature-map height/width in pixels
- cfg_base  in  ADDR_W  word address of pixel (0,0)
- desc_valid  in  1  tile descriptor valid
- desc_ready  out  1  high when idle and config loaded
- desc_in_row, desc_in_col  in  DIM_W+1 signed  window origin; negative means top/left padding
- desc_in_h, desc_in_w  in  DIM_W  window size
- pix_valid  out  1  pixel beat valid
- pix_ready  in  1  consumer accept
- pix_addr  out  ADDR_W  read address; 0 when pix_pad
- pix_pad  out  1  pixel lies outside the image
- pix_buf_idx  out  2*DIM_W  local index r*desc_in_w + c
- pix_first, pix_last  out  1  first / last beat of the tile
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Config: on cfg_valid && cfg_ready, latch img_h, img_w and base, and set cfg_loaded. Config is ignored while RUN. cfg_loaded clears only on reset.
- Descriptor: on desc_valid && desc_ready, latch origin, h and w, clear r and c, then go to RUN. If h == 0 or w == 0, go to DONE instead and emit no beats.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on descriptor accept (nonzero size). IDLE → DONE on descriptor accept (zero size).
  - RUN → DONE when a pix_last beat is accepted.
  - DONE → IDLE unconditionally after one cycle; done = 1 in DONE.
- Beat computation, combinational from the registered r, c and descriptor:
  - ir = in_row + r and ic = in_col + c, signed, DIM_W+2 bits.
  - pix_pad = (ir < 0) || (ir >= img_h) || (ic < 0) || (ic >= img_w).
  - pix_addr = base + ir*img_w + ic when not padded, truncated to ADDR_W; otherwise 0.
  - pix_first = (r == 0 && c == 0). pix_last = (r == h-1 && c == w-1).
- Advance on pix_valid && pix_ready: c++ ; if c == w-1 then c = 0 and r++.
- pix_valid = (state == RUN). cfg_ready = (state == IDLE). desc_ready = (state == IDLE) && cfg_loaded.

## Timing
- Reset: state IDLE, cfg_loaded 0, all latched registers and counters 0. pix_valid, done and desc_ready read 0; cfg_ready reads 1.
- Latency: a descriptor accepted on cycle N presents its first beat on cycle N+1. Throughput is one beat per cycle under continuous pix_ready, so a tile takes h*w cycles plus 1 cycle in DONE.
- A descriptor is accepted at the earliest one cycle after done, because desc_ready is low during DONE.
- Backpressure: while pix_valid && !pix_ready, every pix_* output holds stable.
- Reset asserted mid-tile aborts immediately: the next cycle shows IDLE, no done pulse, and config must be reloaded.
- cfg and desc handshakes in the same cycle: config latches first, but desc_ready already includes the prior cfg_loaded, so the first descriptor can only be taken on a later cycle.
- Address arithmetic wraps modulo 2^ADDR_W and has no overflow flag.

## Test plan
- Top-left pad, with img 8x8, base 0x100, desc (-1,-1,4,4):
  - 16 beats.
  - Beats 0–4, 8 and 12 are pad: 7 pads total.
  - Beat 5 has addr 0x100.
  - Beat 15 has addr 0x112 and pix_last = 1.
  - done pulses one cycle after beat 15 is accepted.
- Bottom-right pad, with img 8x8, base 0, desc (6,6,3,3):
  - Beats 2, 5, 6, 7 and 8 are pad.
  - Beat 0 has addr 54 and beat 4 has addr 63.
- Backpressure: same tile as the first scenario, with pix_ready toggling on a random pattern. The beat sequence is identical to the first scenario, and outputs stay stable on every stalled cycle.
- Zero-size descriptor (h = 0): no pix_valid, and done rises one cycle after acceptance. desc_ready is low for exactly that one cycle.
- Reset mid-tile after beat 6: pix_valid falls, with no done. desc_ready stays 0 until a new config is loaded.
- Back-to-back tiles: desc_valid is held high with two descriptors queued. The second is accepted the cycle after done, and its pix_first beat appears the cycle after that.
